// File: rtl/riscv_divider.sv
// Iterative restoring divide/remainder unit for DIV, DIVU, REM and REMU.
// Retires BITS_PER_CYCLE quotient bits per cycle; the zero-divisor and signed-overflow cases skip the iterations.
module riscv_divider #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
      (WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 8) begin : g_bad_param
    $error("riscv_divider: unsupported WIDTH/BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? negate(v) : v;
  endfunction

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              rem_sel;
  logic              neg_quo;
  logic              neg_rem;
  logic              special;
  logic [WIDTH-1:0]  special_res;
  logic [WIDTH:0]    part_rem;
  logic [WIDTH-1:0]  quo_sr;
  logic [WIDTH-1:0]  divisor;

  logic              accept;
  logic              is_signed;
  logic              sign_a;
  logic              sign_b;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic              b_zero;
  logic              ovf;
  logic [WIDTH-1:0]  spec_val;
  logic [WIDTH:0]    r_nx;
  logic [WIDTH-1:0]  q_nx;
  logic [WIDTH-1:0]  result_val;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;

  assign is_signed = ~in_op[0];
  assign sign_a    = is_signed & in_a[WIDTH-1];
  assign sign_b    = is_signed & in_b[WIDTH-1];
  assign mag_a     = sign_a ? negate(in_a) : in_a;
  assign mag_b     = sign_b ? negate(in_b) : in_b;
  assign b_zero    = (in_b == '0);
  assign ovf       = is_signed && (in_a == MIN_VAL) && (in_b == '1);
  assign spec_val  = b_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : MIN_VAL);

  // Restoring steps chained combinationally within one cycle
  always_comb begin
    r_nx = part_rem;
    q_nx = quo_sr;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      r_nx = {r_nx[WIDTH-1:0], q_nx[WIDTH-1]};
      q_nx = {q_nx[WIDTH-2:0], 1'b0};
      if (r_nx >= {1'b0, divisor}) begin
        r_nx    = r_nx - {1'b0, divisor};
        q_nx[0] = 1'b1;
      end
    end
  end

  assign result_val = special ? special_res
                    : (rem_sel ? fix_sign(r_nx[WIDTH-1:0], neg_rem) : fix_sign(q_nx, neg_quo));

  // Control and output registers; special cases enter CALC at the last count so they finish in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= DONE;
            cnt        <= '0;
            out_result <= result_val;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: ;
      endcase
      if (accept) begin
        state   <= CALC;
        cnt     <= (b_zero || ovf) ? LAST : '0;
        out_tag <= in_tag;
      end
    end
  end

  // Datapath registers need no reset; they are always loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_sel     <= in_op[1];
      neg_quo     <= sign_a ^ sign_b;
      neg_rem     <= sign_a;
      special     <= b_zero || ovf;
      special_res <= spec_val;
      part_rem    <= '0;
      quo_sr      <= mag_a;
      divisor     <= mag_b;
    end else if (state == CALC) begin
      part_rem <= r_nx;
      quo_sr   <= q_nx;
    end
  end

endmodule
